// File: rtl/and_reduce_arbiter.sv
// Round-robin arbiter sharing one N-bit AND reducer between two requesters; words are reduced chunk by chunk.
// Optional build macro AND_EARLY_EXIT_EN finishes a job as soon as any chunk reduces to 0.

module andNbits #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a_i,
    output logic         y_o
);
    assign y_o = &a_i;
endmodule

module and_reduce_arbiter #(
    parameter int unsigned N      = 4,
    parameter int unsigned CHUNKS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic [N*CHUNKS-1:0]   data0,
    input  logic                  req1,
    input  logic [N*CHUNKS-1:0]   data1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  busy,
    output logic                  done,
    output logic                  done_id,
    output logic                  resultado
);
    localparam int unsigned W     = N * CHUNKS;
    localparam int unsigned IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHUNKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     sreg_q, sreg_d;
    logic             acc_q, acc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             owner_q, owner_d;
    logic             prio_q, prio_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             res_q, res_d;
    logic             done_id_q, done_id_d;

    logic             chunk_and;
    logic             winner;
    logic             last_chunk;

    andNbits #(.N(N)) u_and (
        .a_i (sreg_q[N-1:0]),
        .y_o (chunk_and)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sreg_q    <= '0;
            acc_q     <= 1'b1;
            idx_q     <= '0;
            owner_q   <= 1'b0;
            prio_q    <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            res_q     <= 1'b0;
            done_id_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            owner_q   <= owner_d;
            prio_q    <= prio_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            res_q     <= res_d;
            done_id_q <= done_id_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        owner_d    = owner_q;
        prio_d     = prio_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        res_d      = res_q;
        done_id_d  = done_id_q;
        winner     = req1 && (!req0 || prio_q);
        last_chunk = (idx_q == IDX_LAST);

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    sreg_d  = winner ? data1 : data0;
                    acc_d   = 1'b1;
                    idx_d   = '0;
                    owner_d = winner;
                    ack0_d  = !winner;
                    ack1_d  = winner;
                    prio_d  = !winner;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d  = acc_q & chunk_and;
                sreg_d = sreg_q >> N;
                idx_d  = idx_q + 1'b1;
`ifdef AND_EARLY_EXIT_EN
                if (!chunk_and) last_chunk = 1'b1;
`endif
                // Result is captured on the edge entering DONE so it is valid alongside done.
                if (last_chunk) begin
                    res_d     = acc_d;
                    done_id_d = owner_q;
                    state_d   = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign done_id   = done_id_q;
    assign resultado = res_q;

endmodule

// File: tb/tb_and_reduce_arbiter.sv
// Directed self-checking bench for and_reduce_arbiter (default N=4, CHUNKS=4).
// Expected latencies follow AND_EARLY_EXIT_EN when the bench is built with it.

module tb_and_reduce_arbiter;
    logic        clk;
    logic        rst_n;
    logic        req0, req1;
    logic [15:0] data0, data1;
    logic        ack0, ack1, busy, done, done_id, resultado;

    int total = 0;
    int bad   = 0;

    and_reduce_arbiter #(.N(4), .CHUNKS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .data0     (data0),
        .req1      (req1),
        .data1     (data1),
        .ack0      (ack0),
        .ack1      (ack1),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id),
        .resultado (resultado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick_lat(input int lat_full, input int lat_early);
`ifdef AND_EARLY_EXIT_EN
        return lat_early;
`else
        return lat_full;
`endif
    endfunction

    // Issues one request, flips the data right after ack, and checks ack/busy/done timing and result.
    task automatic run_job(input int id, input logic [15:0] d, input int exp_res,
                           input int lat_full, input int lat_early);
        int n;
        int busy_n;
        int seen;
        int lat;
        lat = pick_lat(lat_full, lat_early);
        @(negedge clk);
        if (id == 0) begin req0 = 1'b1; data0 = d; end
        else         begin req1 = 1'b1; data1 = d; end
        @(negedge clk);
        chk("ack_own",   int'(id == 0 ? ack0 : ack1), 1);
        chk("ack_other", int'(id == 0 ? ack1 : ack0), 0);
        chk("busy_ack",  int'(busy), 1);
        req0 = 1'b0; req1 = 1'b0;
        data0 = ~d; data1 = ~d;
        n = 0; busy_n = 1; seen = 0;
        while (seen == 0 && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("ack_one_cycle", int'(ack0 | ack1), 0);
            if (busy) busy_n++;
            if (done) seen = 1;
        end
        chk("done_seen",  seen, 1);
        chk("latency",    n, lat);
        chk("resultado",  int'(resultado), exp_res);
        chk("done_id",    int'(done_id), id);
        chk("busy_cycles", busy_n, lat + 1);
        @(negedge clk);
        chk("done_pulse", int'(done), 0);
        chk("busy_idle",  int'(busy), 0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int g_id[4], g_t[4], d_id[4], d_res[4];
        int ng, nd, t, nd_after, seen;

        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        data0 = '0; data1 = '0;
        #1;
        chk("rst_ack0",      int'(ack0), 0);
        chk("rst_ack1",      int'(ack1), 0);
        chk("rst_busy",      int'(busy), 0);
        chk("rst_done",      int'(done), 0);
        chk("rst_done_id",   int'(done_id), 0);
        chk("rst_resultado", int'(resultado), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_job(0, 16'hFFFF, 1, 4, 4);
        run_job(1, 16'h0000, 0, 4, 1);
        run_job(0, 16'hFF0F, 0, 4, 2);
        run_job(1, 16'hFFFE, 0, 4, 1);
        run_job(0, 16'h7FFF, 0, 4, 4);
        run_job(1, 16'hFFFF, 1, 4, 4);

        // Both requesters held continuously: round-robin order and grant spacing.
        reset_pulse();
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1;
        data0 = 16'hFFFF; data1 = 16'hAAAA;
        ng = 0; nd = 0; t = 0;
        while (nd < 4 && t < 60) begin
            @(negedge clk);
            t++;
            if (ack0 | ack1) begin
                if (ng < 4) begin g_id[ng] = int'(ack1); g_t[ng] = t; end
                ng++;
            end
            if (done) begin
                if (nd < 4) begin d_id[nd] = int'(done_id); d_res[nd] = int'(resultado); end
                nd++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("rr_done_count", nd, 4);
        chk("rr_grant_count", ng, 4);
        for (int k = 0; k < 4; k++) begin
            chk("rr_grant_id", g_id[k], k % 2);
            chk("rr_done_id",  d_id[k], k % 2);
            chk("rr_result",   d_res[k], (k % 2 == 0) ? 1 : 0);
        end
        chk("rr_space01", g_t[1] - g_t[0], 6);
        chk("rr_space12", g_t[2] - g_t[1], pick_lat(4, 1) + 2);
        chk("rr_space23", g_t[3] - g_t[2], 6);
        repeat (3) @(negedge clk);

        // Leave resultado=1 and prio pointing at requester 1 before the abort test.
        run_job(0, 16'hFFFF, 1, 4, 4);

        @(negedge clk);
        req0 = 1'b1; data0 = 16'hFFFF;
        @(negedge clk);
        chk("abort_ack0", int'(ack0), 1);
        req0 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy",      int'(busy), 0);
        chk("abort_done",      int'(done), 0);
        chk("abort_ack0_low",  int'(ack0), 0);
        chk("abort_ack1_low",  int'(ack1), 0);
        chk("abort_resultado", int'(resultado), 0);
        @(negedge clk);
        rst_n = 1'b1;
        nd_after = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) nd_after++;
        end
        chk("abort_no_done", nd_after, 0);

        req0 = 1'b1; req1 = 1'b1;
        data0 = 16'hFFFF; data1 = 16'h0F0F;
        @(negedge clk);
        chk("post_rst_ack0", int'(ack0), 1);
        chk("post_rst_ack1", int'(ack1), 0);
        req0 = 1'b0; req1 = 1'b0;
        seen = 0; t = 0;
        while (seen == 0 && t < 20) begin
            @(negedge clk);
            t++;
            if (done) seen = 1;
        end
        chk("post_rst_done", seen, 1);
        chk("post_rst_res",  int'(resultado), 1);
        chk("post_rst_id",   int'(done_id), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule
